// File: rtl/mul.sv
// Sequential 4x4 unsigned shift-and-add multiplier, self-restarting on operand change.
// Optional macro MUL_EARLY_EXIT_EN: finish CALC once no higher multiplier bits remain.
module mul (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t     state;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] acc;
    logic [1:0] cnt;

    logic [7:0] pp;
    logic [7:0] sum;
    logic [2:0] nxt_idx;
    logic       last;

    always_comb begin
        pp      = rb[cnt] ? ({4'b0, ra} << cnt) : 8'd0;
        sum     = acc + pp;
        nxt_idx = {1'b0, cnt} + 3'd1;
`ifdef MUL_EARLY_EXIT_EN
        // No remaining multiplier bits means the sum is already final.
        last    = (cnt == 2'd3) || ((rb >> nxt_idx) == 4'd0);
`else
        last    = (cnt == 2'd3);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            P     <= 8'd0;
            done  <= 1'b0;
            acc   <= 8'd0;
            cnt   <= 2'd0;
            ra    <= 4'd0;
            rb    <= 4'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    ra    <= A;
                    rb    <= B;
                    acc   <= 8'd0;
                    cnt   <= 2'd0;
                    state <= CALC;
                end
                CALC: begin
                    acc <= sum;
                    cnt <= cnt + 2'd1;
                    if (last) begin
                        P     <= sum;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // P keeps the previous product until the new one lands.
                    if ((A != ra) || (B != rb)) begin
                        ra    <= A;
                        rb    <= B;
                        acc   <= 8'd0;
                        cnt   <= 2'd0;
                        done  <= 1'b0;
                        state <= CALC;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul.sv
// Directed self-checking bench for mul.
// Expected latency follows the build flavour selected by MUL_EARLY_EXIT_EN.
module tb_mul;

    logic       clk;
    logic       rst;
    logic [3:0] A;
    logic [3:0] B;
    logic [7:0] P;
    logic       done;

    int checks = 0;
    int errors = 0;

    mul dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .P    (P),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lat(input logic [3:0] b);
`ifdef MUL_EARLY_EXIT_EN
        if (b[3]) return 4;
        else if (b[2]) return 3;
        else if (b[1]) return 2;
        else return 1;
`else
        return 4;
`endif
    endfunction

    // From DONE: apply new operands, check done drop, old P held, then new result.
    task automatic run(input string tag, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] old_p, input logic [7:0] exp_p);
        A = a;
        B = b;
        step(1);
        chk({tag, "_drop"}, {7'd0, done}, 8'd0);
        chk({tag, "_hold"}, P, old_p);
        step(lat(b) - 1);
        chk({tag, "_busy"}, {7'd0, done}, 8'd0);
        step(1);
        chk({tag, "_done"}, {7'd0, done}, 8'd1);
        chk({tag, "_p"}, P, exp_p);
    endtask

    initial begin
        rst = 1'b1;
        A   = 4'd2;
        B   = 4'd7;
        step(10);
        chk("rst_p", P, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);

        rst = 1'b0;
        step(1);
        chk("cap_done", {7'd0, done}, 8'd0);
        step(lat(4'd7) - 1);
        chk("first_busy", {7'd0, done}, 8'd0);
        step(1);
        chk("first_done", {7'd0, done}, 8'd1);
        chk("first_p", P, 8'h0E);

        run("f_x_3", 4'd15, 4'd3, 8'h0E, 8'h2D);
        run("f_x_f", 4'd15, 4'd15, 8'h2D, 8'hE1);
        run("0_x_9", 4'd0, 4'd9, 8'hE1, 8'h00);
        run("9_x_0", 4'd9, 4'd0, 8'h00, 8'h00);

        // Operand change during CALC is deferred until the result completes.
        A = 4'd2;
        B = 4'd7;
        step(1);
        chk("mid_drop", {7'd0, done}, 8'd0);
        step(1);
        A = 4'd5;
        step(lat(4'd7) - 1);
        chk("mid_first_done", {7'd0, done}, 8'd1);
        chk("mid_first_p", P, 8'h0E);
        step(1);
        chk("mid_redrop", {7'd0, done}, 8'd0);
        chk("mid_hold", P, 8'h0E);
        step(lat(4'd7));
        chk("mid_second_done", {7'd0, done}, 8'd1);
        chk("mid_second_p", P, 8'h23);

        // Reset during CALC, then restart with the current operands.
        A = 4'd3;
        B = 4'd5;
        step(2);
        rst = 1'b1;
        step(1);
        chk("rcalc_p", P, 8'd0);
        chk("rcalc_done", {7'd0, done}, 8'd0);
        rst = 1'b0;
        step(1);
        chk("rcalc_cap", {7'd0, done}, 8'd0);
        step(lat(4'd5) - 1);
        chk("rcalc_busy", {7'd0, done}, 8'd0);
        step(1);
        chk("rcalc_done2", {7'd0, done}, 8'd1);
        chk("rcalc_p2", P, 8'h0F);

        // Steady operands: result and done must hold with no recompute.
        for (int i = 0; i < 50; i++) begin
            step(1);
            chk("steady_done", {7'd0, done}, 8'd1);
            chk("steady_p", P, 8'h0F);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
